// File: rtl/spm_ctrl_if.sv
// spm_ctrl_if: operand/result handshake bundle for spm_ctrl.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds its data stable
// while valid is high and not yet accepted; ready may depend on state only.
//
//   in_valid/in_ready/mc/mp       : operand channel (wrapper -> controller)
//   out_valid/out_ready/prod      : result channel  (controller -> wrapper)
//   busy                          : controller is clearing or shifting
//
// master = user-project side, slave = spm_ctrl side.
interface spm_ctrl_if #(
   parameter int size = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [size-1:0]   mc;
   logic [size-1:0]   mp;
   logic              out_valid;
   logic              out_ready;
   logic [2*size-1:0] prod;
   logic              busy;

   modport master (
      output in_valid, mc, mp, out_ready,
      input  in_ready, out_valid, prod, busy
   );

   modport slave (
      input  in_valid, mc, mp, out_ready,
      output in_ready, out_valid, prod, busy
   );
endinterface

// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencing controller around one serial-parallel multiplier.
//
// Accepts a signed mc/mp pair, clears the multiplier, streams the
// sign-extended multiplier LSB-first into spm.y for 2*size+1 cycles while
// deserialising spm.p into a 2*size-bit product, then presents the product
// until the consumer takes it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (also clears spm asynchronously)
//   bus        spm_ctrl_if slave modport (operand/result handshakes, busy)
//   state_dbg  current FSM state (IDLE=0, CLR=1, SHIFT=2, DONE=3)
//
// spm: serial-parallel two's-complement multiplier. x is held parallel, y
// arrives one bit per cycle LSB-first, p emits one product bit per cycle,
// one cycle after the y bit that completes it. rst clears it asynchronously.
module spm #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [size-1:0] x,
   input  logic            y,
   output logic            p
);
   // acc holds the running partial sum already divided by 2^i; size+1 bits
   // are enough because |acc| <= 2^(size-1) and |x| <= 2^(size-1).
   logic [size:0] acc;
   logic [size:0] sum;

   always_comb begin
      sum = acc;
      if (y) sum = acc + {x[size-1], x};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         p   <= 1'b0;
      end else begin
         acc <= {sum[size], sum[size:1]};
         p   <= sum[0];
      end
   end
endmodule

module spm_ctrl #(
   parameter int size = 32
) (
   input  logic         clk,
   input  logic         rst,
   spm_ctrl_if.slave    bus,
   output logic [1:0]   state_dbg
);
   localparam int cw = $clog2(2*size+1);
   localparam int iw = (size > 1) ? $clog2(size) : 1;
   localparam logic [cw-1:0] cnt_size = cw'(size);
   localparam logic [cw-1:0] cnt_last = cw'(2*size);

   typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [size-1:0]   mc_q;
   logic [size-1:0]   mp_q;
   logic [cw-1:0]     cnt;
   logic [2*size-1:0] prod_q;
   logic              spm_clr;
   logic              spm_rst;
   logic              spm_y;
   logic              spm_p;

   // Both terms come straight from flops, so the async clear never glitches.
   assign spm_rst   = rst | spm_clr;
   assign bus.prod  = prod_q;
   assign state_dbg = state;

   spm #(.size(size)) u_spm (
      .clk (clk),
      .rst (spm_rst),
      .x   (mc_q),
      .y   (spm_y),
      .p   (spm_p)
   );

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      spm_y         = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = CLR;
         end
         CLR: begin
            bus.busy  = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            bus.busy = 1'b1;
            // Multiplier bits, then its sign bit repeated, then a final 0
            // cycle that only flushes the last product bit out of spm.
            if (cnt < cnt_size)      spm_y = mp_q[cnt[iw-1:0]];
            else if (cnt < cnt_last) spm_y = mp_q[size-1];
            if (cnt == cnt_last) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mc_q    <= '0;
         mp_q    <= '0;
         cnt     <= '0;
         prod_q  <= '0;
         spm_clr <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mc_q    <= bus.mc;
                  mp_q    <= bus.mp;
                  prod_q  <= '0;
                  spm_clr <= 1'b1;
               end
            end
            CLR: begin
               spm_clr <= 1'b0;
               cnt     <= '0;
            end
            SHIFT: begin
               // spm.p lags y by one cycle, so nothing valid arrives at cnt=0.
               if (cnt != '0) prod_q <= {spm_p, prod_q[2*size-1:1]};
               if (cnt != cnt_last) cnt <= cnt + cw'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_spm_ctrl.sv
// tb_spm_ctrl: bench for spm_ctrl with one size=8 and one size=32 instance.
module tb_spm_ctrl;
   logic       clk = 1'b0;
   logic       rst8;
   logic       rst32;
   logic [1:0] st8;
   logic [1:0] st32;
   int         total = 0;
   int         bad = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   spm_ctrl_if #(.size(8))  b8 ();
   spm_ctrl_if #(.size(32)) b32 ();

   spm_ctrl #(.size(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8),  .state_dbg(st8));
   spm_ctrl #(.size(32)) dut32 (.clk(clk), .rst(rst32), .bus(b32), .state_dbg(st32));

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
      longint r;
      r = longint'($signed(a)) * longint'($signed(b));
      return r[15:0];
   endfunction

   function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b);
      longint r;
      r = longint'($signed(a)) * longint'($signed(b));
      return r[63:0];
   endfunction

   // Issues one operand pair to the size-8 instance (assumed idle) and waits
   // for the result; returns at #1 after the edge where out_valid rose.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, output logic [15:0] p,
                       output int lat, output int busy_n, output bit to);
      @(posedge clk); #1;
      b8.mc = a; b8.mp = b; b8.in_valid = 1'b1;
      @(posedge clk); #1;
      b8.in_valid = 1'b0; b8.mc = 8'($urandom); b8.mp = 8'($urandom);
      lat = 1; busy_n = 0;
      while (!b8.out_valid && lat < 60) begin
         if (b8.busy) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      to = !b8.out_valid;
      p  = b8.prod;
   endtask

   task automatic pop8;
      b8.out_ready = 1'b1;
      @(posedge clk); #1;
      b8.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst8 = 1'b1; rst32 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1'b0; rst32 = 1'b0;
      total++; if (b8.in_ready !== 1'b1) begin $display("FAIL rst8_in_ready got=%b exp=1", b8.in_ready); bad++; end
      total++; if (b8.out_valid !== 1'b0) begin $display("FAIL rst8_out_valid got=%b exp=0", b8.out_valid); bad++; end
      total++; if (b8.busy !== 1'b0) begin $display("FAIL rst8_busy got=%b exp=0", b8.busy); bad++; end
      total++; if (b8.prod !== 16'h0000) begin $display("FAIL rst8_prod got=%h exp=0000", b8.prod); bad++; end
      total++; if (b32.in_ready !== 1'b1) begin $display("FAIL rst32_in_ready got=%b exp=1", b32.in_ready); bad++; end
      total++; if (b32.out_valid !== 1'b0) begin $display("FAIL rst32_out_valid got=%b exp=0", b32.out_valid); bad++; end
      total++; if (b32.busy !== 1'b0) begin $display("FAIL rst32_busy got=%b exp=0", b32.busy); bad++; end
      total++; if (b32.prod !== 64'h0) begin $display("FAIL rst32_prod got=%h exp=0", b32.prod); bad++; end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (b8.prod !== 16'h0000 || b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
            $display("FAIL idle8 cyc=%0d got prod=%h ov=%b ir=%b exp prod=0000 ov=0 ir=1",
                     i, b8.prod, b8.out_valid, b8.in_ready);
            bad++;
         end
      end
   endtask

   task automatic test_basic;
      logic [15:0] p; int lat; int bn; bit to;
      run8(8'd3, 8'd5, p, lat, bn, to);
      total++; if (to) begin $display("FAIL basic_timeout got=no_out_valid exp=out_valid"); bad++; end
      total++; if (lat != 19) begin $display("FAIL basic_latency got=%0d exp=19", lat); bad++; end
      total++; if (bn != 18) begin $display("FAIL basic_busy_cycles got=%0d exp=18", bn); bad++; end
      total++; if (p !== 16'h000F) begin $display("FAIL basic_prod got=%h exp=000f", p); bad++; end
      pop8();
      total++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
         $display("FAIL basic_after_pop got ir=%b ov=%b exp ir=1 ov=0", b8.in_ready, b8.out_valid); bad++;
      end
   endtask

   task automatic test_signed;
      logic [7:0]  a [4];
      logic [7:0]  b [4];
      logic [15:0] e [4];
      logic [15:0] p; int lat; int bn; bit to;
      a[0] = 8'd3;   b[0] = 8'hFE; e[0] = 16'hFFFA;
      a[1] = 8'h80;  b[1] = 8'h80; e[1] = 16'h4000;
      a[2] = 8'h80;  b[2] = 8'h7F; e[2] = 16'hC080;
      a[3] = 8'h00;  b[3] = 8'hFF; e[3] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         run8(a[i], b[i], p, lat, bn, to);
         total++;
         if (to || p !== e[i]) begin
            $display("FAIL signed_%0d got=%h to=%b exp=%h", i, p, to, e[i]); bad++;
         end
         pop8();
      end
   endtask

   task automatic test_random8;
      logic [7:0] a; logic [7:0] b; logic [15:0] p; int lat; int bn; bit to;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         run8(a, b, p, lat, bn, to);
         total++;
         if (to || p !== ref8(a, b) || lat != 19) begin
            $display("FAIL rand8_%0d a=%h b=%h got=%h lat=%0d exp=%h lat=19", i, a, b, p, lat, ref8(a, b)); bad++;
         end
         pop8();
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] p; logic [15:0] e; int lat; int bn; bit to;
      e = ref8(8'd25, 8'hF3);
      run8(8'd25, 8'hF3, p, lat, bn, to);
      total++; if (to || p !== e) begin $display("FAIL bp_first got=%h to=%b exp=%h", p, to, e); bad++; end
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            b8.mc = 8'd99; b8.mp = 8'd99; b8.in_valid = 1'b1;
            total++; if (b8.in_ready !== 1'b0) begin $display("FAIL bp_in_ready got=%b exp=0", b8.in_ready); bad++; end
         end
         if (i == 5) b8.in_valid = 1'b0;
         @(posedge clk); #1;
         total++;
         if (b8.out_valid !== 1'b1 || b8.prod !== e) begin
            $display("FAIL bp_hold cyc=%0d got ov=%b prod=%h exp ov=1 prod=%h", i, b8.out_valid, b8.prod, e); bad++;
         end
      end
      pop8();
      total++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
         $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", b8.in_ready, b8.out_valid); bad++;
      end
      run8(8'hFB, 8'd6, p, lat, bn, to);
      total++; if (to || p !== 16'hFFE2) begin $display("FAIL bp_next got=%h to=%b exp=ffe2", p, to); bad++; end
      pop8();
   endtask

   task automatic test_reset_mid;
      logic [15:0] p; int lat; int bn; bit to; bit seen;
      @(posedge clk); #1;
      b8.mc = 8'd100; b8.mp = 8'hFD; b8.in_valid = 1'b1;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst8 = 1'b1;
      @(posedge clk); #1;
      rst8 = 1'b0;
      total++; if (b8.in_ready !== 1'b1) begin $display("FAIL midrst_in_ready got=%b exp=1", b8.in_ready); bad++; end
      total++; if (b8.out_valid !== 1'b0) begin $display("FAIL midrst_out_valid got=%b exp=0", b8.out_valid); bad++; end
      total++; if (b8.busy !== 1'b0) begin $display("FAIL midrst_busy got=%b exp=0", b8.busy); bad++; end
      total++; if (b8.prod !== 16'h0000) begin $display("FAIL midrst_prod got=%h exp=0000", b8.prod); bad++; end
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (b8.out_valid) seen = 1'b1;
      end
      total++; if (seen) begin $display("FAIL midrst_no_result got=out_valid exp=none"); bad++; end
      run8(8'd7, 8'hF7, p, lat, bn, to);
      total++; if (to || p !== 16'hFFC1) begin $display("FAIL midrst_next got=%h to=%b exp=ffc1", p, to); bad++; end
      pop8();
   endtask

   task automatic test_random32;
      int n_ops;
      int got;
      bit abort;
      n_ops = 1000; got = 0; abort = 1'b0;
      exp_q.delete();
      fork
         begin
            for (int i = 0; i < n_ops && !abort; i++) begin
               logic [31:0] a; logic [31:0] b; int w; int k;
               a = $urandom; b = $urandom;
               k = $urandom_range(0, 15);
               if (k == 0) a = 32'h8000_0000;
               if (k == 1) b = 32'h8000_0000;
               if (k == 2) begin a = 32'h8000_0000; b = 32'h8000_0000; end
               if (k == 3) b = 32'hFFFF_FFFF;
               if (k == 4) a = 32'h0;
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
               end
               b32.mc = a; b32.mp = b; b32.in_valid = 1'b1;
               w = 0;
               while (!b32.in_ready && w < 300) begin @(posedge clk); #1; w++; end
               total++;
               if (!b32.in_ready) begin
                  $display("FAIL rand32_accept op=%0d got in_ready=0 exp=1 within 300 cycles", i); bad++; abort = 1'b1;
               end else begin
                  exp_q.push_back(ref32(a, b));
                  @(posedge clk); #1;
               end
               b32.in_valid = 1'b0;
               b32.mc = $urandom; b32.mp = $urandom;
            end
         end
         begin
            int idle;
            logic [63:0] e;
            idle = 0;
            while (got < n_ops && !abort) begin
               b32.out_ready = ($urandom_range(0, 3) != 0);
               if (b32.out_valid && b32.out_ready) begin
                  total++;
                  if (exp_q.size() == 0) begin
                     $display("FAIL rand32_extra got=%h exp=no_result", b32.prod); bad++;
                  end else begin
                     e = exp_q.pop_front();
                     if (b32.prod !== e) begin
                        $display("FAIL rand32_prod n=%0d got=%h exp=%h", got, b32.prod, e); bad++;
                     end
                  end
                  got++;
                  idle = 0;
               end
               @(posedge clk); #1;
               idle++;
               if (idle > 400) begin
                  total++; bad++;
                  $display("FAIL rand32_timeout got=%0d results exp=%0d", got, n_ops);
                  abort = 1'b1;
               end
            end
            b32.out_ready = 1'b0;
         end
      join
      total++;
      if (exp_q.size() != 0) begin $display("FAIL rand32_leftover got=%0d exp=0", exp_q.size()); bad++; end
   endtask

   initial begin
      rst8 = 1'b1; rst32 = 1'b1;
      b8.in_valid = 1'b0;  b8.out_ready = 1'b0;  b8.mc = '0;  b8.mp = '0;
      b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.mc = '0; b32.mp = '0;
      test_reset();
      test_basic();
      test_signed();
      test_random8();
      test_backpressure();
      test_reset_mid();
      test_random32();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
